// File: rtl/gp_regfile_sb.sv
// General-purpose register file with two registered read ports, one write port,
// write-to-read bypass, optional hardwired zero register and a per-register pending-load flag.
module gp_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        SelX,
  input  logic [ADDR_W-1:0]        SelY,
  input  logic [ADDR_W-1:0]        SelZ,
  input  logic [1:0]               MemInstruction,
  input  logic [DATA_W-1:0]        MemData,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        A,
  output logic [DATA_W-1:0]        B,
  output logic                     A_valid,
  output logic                     B_valid,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int         NREGS    = 2 ** ADDR_W;
  localparam logic [1:0] MI_LOAD  = 2'b01;
  localparam logic [1:0] MI_WRITE = 2'b11;

  logic              dest_zero;
  logic              wr_en;
  logic              ld_en;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // A hardwired zero register swallows both writes and load issues.
  assign dest_zero = (ZERO_REG != 0) && (SelZ == '0);
  assign wr_en     = (MemInstruction == MI_WRITE) && !dest_zero;
  assign ld_en     = (MemInstruction == MI_LOAD) && !dest_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[SelZ] <= MemData;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[SelZ] = 1'b0;
    end else if (ld_en) begin
      busy_d[SelZ] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [ADDR_W-1:0] sel;
      logic [DATA_W-1:0] data_d;
      logic [DATA_W-1:0] data_q;
      logic              valid_d;
      logic              valid_q;

      assign sel = (gi == 0) ? SelX : SelY;

      // Priority: zero register, then same-cycle write bypass, then same-cycle load issue.
      always_comb begin
        data_d  = regs_q[sel];
        valid_d = ~busy_q[sel];
        if ((ZERO_REG != 0) && (sel == '0)) begin
          data_d  = '0;
          valid_d = 1'b1;
        end else if ((MemInstruction == MI_WRITE) && (sel == SelZ)) begin
          data_d  = MemData;
          valid_d = 1'b1;
        end else if ((MemInstruction == MI_LOAD) && (sel == SelZ)) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (rd_en) begin
          data_q  <= data_d;
          valid_q <= valid_d;
        end
      end
    end
  endgenerate

  assign A       = g_port[0].data_q;
  assign A_valid = g_port[0].valid_q;
  assign B       = g_port[1].data_q;
  assign B_valid = g_port[1].valid_q;

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Scoreboard bench: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus; a
// behavioural model queues expected outputs and a monitor compares them after each edge.
module tb_gp_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  SelX = '0, SelY = '0, SelZ = '0;
  logic [1:0]  MemInstruction = '0;
  logic [31:0] MemData = '0;
  logic        rd_en = 1'b0;

  logic [31:0] a0, b0, a1, b1;
  logic        av0, bv0, av1, bv1;
  logic [7:0]  bz0, bz1;

  always #5 clk = ~clk;

  gp_regfile_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .SelX(SelX), .SelY(SelY), .SelZ(SelZ),
    .MemInstruction(MemInstruction), .MemData(MemData), .rd_en(rd_en),
    .A(a0), .B(b0), .A_valid(av0), .B_valid(bv0), .busy(bz0)
  );

  gp_regfile_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .SelX(SelX), .SelY(SelY), .SelZ(SelZ),
    .MemInstruction(MemInstruction), .MemData(MemData), .rd_en(rd_en),
    .A(a1), .B(b1), .A_valid(av1), .B_valid(bv1), .busy(bz1)
  );

  typedef struct {
    int          id;
    logic [31:0] a0, b0, a1, b1;
    logic        av0, bv0, av1, bv1;
    logic [7:0]  bz0, bz1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference state per instance: index 0 = plain, 1 = hardwired zero register.
  logic [31:0] m_mem  [2][8];
  logic [7:0]  m_busy [2];
  logic [31:0] m_a [2], m_b [2];
  logic        m_av [2], m_bv [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      for (int r = 0; r < 8; r++) m_mem[v][r] = '0;
      m_busy[v] = '0;
      m_a[v] = '0; m_b[v] = '0; m_av[v] = 1'b0; m_bv[v] = 1'b0;
    end
  endtask

  // What a read port of instance v returns for select s given this cycle's inputs.
  task automatic mread(input int v, input logic [2:0] s, output logic [31:0] d, output logic ok);
    if (v == 1 && s == 3'd0) begin
      d = '0; ok = 1'b1;
    end else if (MemInstruction == 2'b11 && s == SelZ) begin
      d = MemData; ok = 1'b1;
    end else if (MemInstruction == 2'b01 && s == SelZ) begin
      d = m_mem[v][s]; ok = 1'b0;
    end else begin
      d = m_mem[v][s]; ok = !m_busy[v][s];
    end
  endtask

  task automatic step(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                      input logic [1:0] mi, input logic [31:0] md, input logic re);
    exp_t        e;
    logic [31:0] da, db;
    logic        oa, ob;
    @(negedge clk);
    SelX = x; SelY = y; SelZ = z; MemInstruction = mi; MemData = md; rd_en = re;
    for (int v = 0; v < 2; v++) begin
      mread(v, x, da, oa);
      mread(v, y, db, ob);
      if (re) begin
        m_a[v] = da; m_av[v] = oa; m_b[v] = db; m_bv[v] = ob;
      end
      if (!(v == 1 && z == 3'd0)) begin
        if (mi == 2'b11) begin
          m_mem[v][z] = md; m_busy[v][z] = 1'b0;
        end else if (mi == 2'b01) begin
          m_busy[v][z] = 1'b1;
        end
      end
    end
    e.id = n_txn++;
    e.a0 = m_a[0]; e.b0 = m_b[0]; e.av0 = m_av[0]; e.bv0 = m_bv[0]; e.bz0 = m_busy[0];
    e.a1 = m_a[1]; e.b1 = m_b[1]; e.av1 = m_av[1]; e.bv1 = m_bv[1]; e.bz1 = m_busy[1];
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    MemInstruction = 2'b00; rd_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_A0"}, a0, 32'h0);   chk({pfx, "_B0"}, b0, 32'h0);
    chk({pfx, "_Av0"}, {31'h0, av0}, 32'h0); chk({pfx, "_Bv0"}, {31'h0, bv0}, 32'h0);
    chk({pfx, "_busy0"}, {24'h0, bz0}, 32'h0);
    chk({pfx, "_A1"}, a1, 32'h0);   chk({pfx, "_B1"}, b1, 32'h0);
    chk({pfx, "_Av1"}, {31'h0, av1}, 32'h0); chk({pfx, "_Bv1"}, {31'h0, bv1}, 32'h0);
    chk({pfx, "_busy1"}, {24'h0, bz1}, 32'h0);
  endtask

  // Monitor: every edge that had stimulus queued produces one comparable output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d: A0=%h/%0b B0=%h/%0b busy0=%h A1=%h/%0b B1=%h/%0b busy1=%h",
                 e.id, a0, av0, b0, bv0, bz0, a1, av1, b1, bv1, bz1);
        chk("A0", a0, e.a0);  chk("B0", b0, e.b0);
        chk("Av0", {31'h0, av0}, {31'h0, e.av0}); chk("Bv0", {31'h0, bv0}, {31'h0, e.bv0});
        chk("busy0", {24'h0, bz0}, {24'h0, e.bz0});
        chk("A1", a1, e.a1);  chk("B1", b1, e.b1);
        chk("Av1", {31'h0, av1}, {31'h0, e.av1}); chk("Bv1", {31'h0, bv1}, {31'h0, e.bv1});
        chk("busy1", {24'h0, bz1}, {24'h0, e.bz1});
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk_all_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Write then read on both ports.
    step(3'd0, 3'd0, 3'd3, 2'b11, 32'hDEADBEEF, 1'b1);
    step(3'd3, 3'd3, 3'd0, 2'b00, 32'h0, 1'b1);
    // Same-cycle bypass.
    step(3'd5, 3'd5, 3'd5, 2'b11, 32'h12345678, 1'b1);
    // Load pending, repeated reads, then load return with bypass.
    step(3'd0, 3'd0, 3'd2, 2'b01, 32'h0, 1'b1);
    repeat (3) step(3'd2, 3'd2, 3'd0, 2'b10, 32'h0, 1'b1);
    step(3'd2, 3'd2, 3'd2, 2'b11, 32'hA5A5A5A5, 1'b1);
    // Register 0 write and load.
    step(3'd0, 3'd0, 3'd0, 2'b11, 32'hFFFFFFFF, 1'b1);
    step(3'd0, 3'd0, 3'd0, 2'b01, 32'h0, 1'b1);
    step(3'd0, 3'd0, 3'd1, 2'b00, 32'h0, 1'b1);
    // Hold with rd_en low, then release.
    step(3'd1, 3'd1, 3'd1, 2'b11, 32'h1, 1'b0);
    step(3'd1, 3'd1, 3'd0, 2'b00, 32'h0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step(3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
           2'($urandom_range(3)), $urandom(), 1'($urandom_range(3) != 0));
    end

    // Pending loads on R0..R3 and R6, then asynchronous reset mid-cycle.
    step(3'd4, 3'd5, 3'd4, 2'b11, 32'h0BADF00D, 1'b1);
    for (int i = 0; i < 4; i++) step(3'd4, 3'd4, 3'(i), 2'b01, 32'h0, 1'b0);
    step(3'd4, 3'd6, 3'd6, 2'b01, 32'h0, 1'b1);
    idle();
    #2 rst = 1'b0;
    #1 chk_all_zero("arst");
    model_reset();
    @(posedge clk);
    #1 chk_all_zero("arst_hold");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) step(3'(i), 3'(7 - i), 3'd0, 2'b00, 32'h0, 1'b1);
    // Late load return after reset writes normally.
    step(3'd6, 3'd6, 3'd6, 2'b11, 32'hCAFEF00D, 1'b1);
    step(3'd6, 3'd0, 3'd0, 2'b00, 32'h0, 1'b1);
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
